// File: rtl/vga_rom_pic_bounce.sv
// VGA timing generator drawing a bouncing RGB565 ROM picture over a flat background.
// Latency: rgb/hsync/vsync trail the h/v counters by 2 pixel-enable ticks; the ROM is read 1 tick ahead.
// Backpressure: none; free-running raster, and the ROM must return data within one sys_clk of rom_addr.
module vga_rom_pic_bounce #(
  parameter int          H_SYNC   = 96,
  parameter int          H_BACK   = 48,
  parameter int          H_VALID  = 640,
  parameter int          H_FRONT  = 16,
  parameter int          V_SYNC   = 2,
  parameter int          V_BACK   = 33,
  parameter int          V_VALID  = 480,
  parameter int          V_FRONT  = 10,
  parameter int          PIC_W    = 100,
  parameter int          PIC_H    = 100,
  parameter int          ROM_AW   = 14,
  parameter int          CLK_DIV  = 2,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              move_en,
  input  logic [3:0]        step,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  // One spare bit so that x0 + step never wraps before the edge test.
  localparam int CW        = $clog2(MAX_TOTAL) + 1;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYN_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYN_END = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CW-1:0] V_ACT_BEG = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_SYNC + V_BACK + V_VALID);
  localparam logic [CW-1:0] X_MAX     = CW'(H_VALID - PIC_W);
  localparam logic [CW-1:0] Y_MAX     = CW'(V_VALID - PIC_H);
  localparam logic [CW-1:0] PIC_W_C   = CW'(PIC_W);
  localparam logic [CW-1:0] PIC_H_C   = CW'(PIC_H);

  // Per-pixel attributes carried from the counter stage to the output stage.
  typedef struct packed {
    logic act;  // inside the visible area
    logic pic;  // inside the picture window
    logic hs;   // horizontal sync asserted
    logic vs;   // vertical sync asserted
    logic sof;  // counter position (0,0)
  } pix_meta_t;

  logic [DW-1:0]     div_cnt;
  logic              pix_en;
  logic              line_end;
  logic              frame_end;
  logic [CW-1:0]     h_cnt;
  logic [CW-1:0]     v_cnt;
  logic [CW-1:0]     px;
  logic [CW-1:0]     py;
  logic              h_act;
  logic              v_act;
  logic              in_pic;
  logic [ROM_AW-1:0] addr_calc;
  pix_meta_t         s1_now;
  pix_meta_t         s1_meta;

  logic [CW-1:0]     x0;
  logic [CW-1:0]     y0;
  logic              dx_right;
  logic              dy_down;
  logic [CW-1:0]     x0_nxt;
  logic [CW-1:0]     y0_nxt;
  logic              dx_nxt;
  logic              dy_nxt;
  logic [CW-1:0]     stp;
  logic              move_now;

  assign pix_en    = (div_cnt == DIV_LAST);
  assign line_end  = pix_en && (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign stp       = CW'(step);
  assign move_now  = move_en && (step != 4'd0);

  // Pixel-enable divider: one tick every CLK_DIV sys_clk (every cycle when CLK_DIV is 1).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Raster counters: h advances per pixel tick, v advances on each h wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Decode the current counter position into region flags and a picture address.
  always_comb begin
    h_act     = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act     = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    // Offsets wrap outside the active area; they are only trusted when h_act/v_act hold.
    px        = h_cnt - H_ACT_BEG;
    py        = v_cnt - V_ACT_BEG;
    in_pic    = h_act && v_act &&
                (px >= x0) && (px < x0 + PIC_W_C) &&
                (py >= y0) && (py < y0 + PIC_H_C);
    // Full-width product, then keep the low ROM_AW bits.
    addr_calc = ROM_AW'(32'(py - y0) * 32'(PIC_W) + 32'(px - x0));
    s1_now     = '0;
    s1_now.act = h_act && v_act;
    s1_now.pic = in_pic;
    s1_now.hs  = (h_cnt < H_SYN_END);
    s1_now.vs  = (v_cnt < V_SYN_END);
    s1_now.sof = (h_cnt == '0) && (v_cnt == '0);
  end

  // Next picture origin and heading per axis; walls clamp the origin and reverse direction.
  always_comb begin
    x0_nxt = x0;
    dx_nxt = dx_right;
    y0_nxt = y0;
    dy_nxt = dy_down;
    if (dx_right) begin
      if (x0 + stp >= X_MAX) begin
        x0_nxt = X_MAX;
        dx_nxt = 1'b0;
      end else begin
        x0_nxt = x0 + stp;
      end
    end else begin
      if (x0 <= stp) begin
        x0_nxt = '0;
        dx_nxt = 1'b1;
      end else begin
        x0_nxt = x0 - stp;
      end
    end
    if (dy_down) begin
      if (y0 + stp >= Y_MAX) begin
        y0_nxt = Y_MAX;
        dy_nxt = 1'b0;
      end else begin
        y0_nxt = y0 + stp;
      end
    end else begin
      if (y0 <= stp) begin
        y0_nxt = '0;
        dy_nxt = 1'b1;
      end else begin
        y0_nxt = y0 - stp;
      end
    end
  end

  // Motion state only moves on the last tick of a frame, so the origin is fixed for a whole frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x0       <= '0;
      y0       <= '0;
      dx_right <= 1'b1;
      dy_down  <= 1'b1;
    end else if (frame_end && move_now) begin
      x0       <= x0_nxt;
      y0       <= y0_nxt;
      dx_right <= dx_nxt;
      dy_down  <= dy_nxt;
    end
  end

  // Stage 1: launch the ROM read and register the attributes of the same pixel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_meta  <= '0;
      rom_addr <= '0;
    end else if (pix_en) begin
      s1_meta <= s1_now;
      if (in_pic) begin
        rom_addr <= addr_calc;
      end
    end
  end

  // Stage 2: pick ROM data, background or black, and drive syncs at the selected polarity.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb   <= 16'h0000;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else if (pix_en) begin
      rgb   <= s1_meta.pic ? rom_data : (s1_meta.act ? BG_COLOR : 16'h0000);
      hsync <= s1_meta.hs ? SYNC_POL : ~SYNC_POL;
      vsync <= s1_meta.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Single sys_clk strobe alongside the first output pixel of each frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && s1_meta.sof;
    end
  end

endmodule

// File: tb/tb_vga_rom_pic_bounce.sv
// Bench for vga_rom_pic_bounce: two small-raster instances (CLK_DIV 1 and 3) against a position-level model.
// Latency: expected outputs are derived from the pixel index two ticks earlier.
// Backpressure: none; inputs change only on the falling clock edge.
module tb_vga_rom_pic_bounce;

  localparam int HS = 2, HB = 2, HV = 16, HF = 2;
  localparam int VS = 1, VB = 1, VV = 12, VF = 1;
  localparam int PW = 4, PH = 3, AW = 8;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FT = HT * VT;
  localparam logic [15:0] BG = 16'h07E0;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          move_en   = 1'b0;
  logic [3:0]    step      = 4'd0;
  logic [AW-1:0] rom_addr0, rom_addr1;
  logic [15:0]   rom_data0 = 16'h0000;
  logic [15:0]   rom_data1 = 16'h0000;
  logic [15:0]   rgb0, rgb1;
  logic          hsync0, hsync1, vsync0, vsync1, fs0, fs1;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int divs [2] = '{1, 3};
  int xs [2][256];
  int ys [2][256];
  int dxr [2];
  int dyd [2];
  int exp_addr [2];

  always #5 sys_clk = ~sys_clk;

  vga_rom_pic_bounce #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .PIC_W(PW), .PIC_H(PH), .ROM_AW(AW), .CLK_DIV(1),
    .BG_COLOR(BG), .SYNC_POL(1'b0)
  ) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .move_en(move_en), .step(step),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .rgb(rgb0),
    .hsync(hsync0), .vsync(vsync0), .frame_start(fs0)
  );

  vga_rom_pic_bounce #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .PIC_W(PW), .PIC_H(PH), .ROM_AW(AW), .CLK_DIV(3),
    .BG_COLOR(BG), .SYNC_POL(1'b0)
  ) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .move_en(move_en), .step(step),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .rgb(rgb1),
    .hsync(hsync1), .vsync(vsync1), .frame_start(fs1)
  );

  function automatic logic [15:0] rom_f(input int a);
    logic [15:0] r;
    r = 16'(a * 40503) ^ 16'h1234;
    return r;
  endfunction

  // ROM for the single-cycle pixel rate settles within the clock; the divided one is a plain registered ROM.
  always @(negedge sys_clk) rom_data0 <= rom_f(int'(rom_addr0));
  always @(posedge sys_clk) rom_data1 <= rom_f(int'(rom_addr1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  function automatic bit is_active(input int pos);
    int h, v;
    h = pos % HT;
    v = (pos / HT) % VT;
    return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
  endfunction

  function automatic bit in_pic(input int k, input int pos);
    int px, py, f;
    if (!is_active(pos)) return 1'b0;
    px = pos % HT - (HS + HB);
    py = (pos / HT) % VT - (VS + VB);
    f  = (pos / FT) % 256;
    return (px >= xs[k][f]) && (px < xs[k][f] + PW) && (py >= ys[k][f]) && (py < ys[k][f] + PH);
  endfunction

  function automatic int pic_addr(input int k, input int pos);
    int px, py, f;
    px = pos % HT - (HS + HB);
    py = (pos / HT) % VT - (VS + VB);
    f  = (pos / FT) % 256;
    return ((py - ys[k][f]) * PW + (px - xs[k][f])) % 256;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      xs[k][0]    = 0;
      ys[k][0]    = 0;
      dxr[k]      = 1;
      dyd[k]      = 1;
      exp_addr[k] = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rgb0"}, 32'(rgb0), 0);
    chk({tag, "_rgb1"}, 32'(rgb1), 0);
    chk({tag, "_addr0"}, 32'(rom_addr0), 0);
    chk({tag, "_addr1"}, 32'(rom_addr1), 0);
    chk({tag, "_fs0"}, 32'(fs0), 0);
    chk({tag, "_fs1"}, 32'(fs1), 0);
    chk({tag, "_hs0"}, 32'(hsync0), 1);
    chk({tag, "_vs1"}, 32'(vsync1), 1);
  endtask

  // Expected outputs during cycle t: pixel index p = t / D, outputs show pixel p-2.
  task automatic model_check(input int k);
    int d, p, q, h, v, e_rgb, e_hs, e_vs, e_fs;
    d = divs[k];
    p = t / d;
    if ((t % d == 0) && (p >= 1) && in_pic(k, p - 1)) exp_addr[k] = pic_addr(k, p - 1);
    e_fs  = ((t % d == 0) && (p >= 2) && ((p - 2) % FT == 0)) ? 1 : 0;
    e_rgb = 0;
    e_hs  = 1;
    e_vs  = 1;
    if (p >= 2) begin
      q    = p - 2;
      h    = q % HT;
      v    = (q / HT) % VT;
      e_hs = (h < HS) ? 0 : 1;
      e_vs = (v < VS) ? 0 : 1;
      if (in_pic(k, q)) e_rgb = int'(rom_f(pic_addr(k, q)));
      else if (is_active(q)) e_rgb = int'(BG);
    end
    chk($sformatf("d%0d_rgb", k), 32'((k == 0) ? rgb0 : rgb1), 32'(e_rgb));
    chk($sformatf("d%0d_hsync", k), 32'((k == 0) ? hsync0 : hsync1), 32'(e_hs));
    chk($sformatf("d%0d_vsync", k), 32'((k == 0) ? vsync0 : vsync1), 32'(e_vs));
    chk($sformatf("d%0d_frame_start", k), 32'((k == 0) ? fs0 : fs1), 32'(e_fs));
    chk($sformatf("d%0d_rom_addr", k), 32'((k == 0) ? rom_addr0 : rom_addr1), 32'(exp_addr[k]));
  endtask

  // On the last tick of a frame, derive the next frame's origin from the bounce rules.
  task automatic model_boundary(input int k);
    int d, p, f, nx, ny, s;
    d = divs[k];
    p = t / d;
    if ((t % d == d - 1) && (p % FT == FT - 1)) begin
      f  = p / FT;
      nx = xs[k][f % 256];
      ny = ys[k][f % 256];
      s  = int'(step);
      if (move_en && s != 0) begin
        if (dxr[k] == 1) begin
          if (nx + s >= HV - PW) begin nx = HV - PW; dxr[k] = 0; end
          else nx = nx + s;
        end else begin
          if (nx <= s) begin nx = 0; dxr[k] = 1; end
          else nx = nx - s;
        end
        if (dyd[k] == 1) begin
          if (ny + s >= VV - PH) begin ny = VV - PH; dyd[k] = 0; end
          else ny = ny + s;
        end else begin
          if (ny <= s) begin ny = 0; dyd[k] = 1; end
          else ny = ny - s;
        end
      end
      xs[k][(f + 1) % 256] = nx;
      ys[k][(f + 1) % 256] = ny;
    end
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 39) == 0) move_en = ($urandom_range(0, 4) != 0);
    if ($urandom_range(0, 29) == 0)
      step = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endtask

  task automatic run(input int n, input bit rnd);
    repeat (n) begin
      model_check(0);
      model_check(1);
      model_boundary(0);
      model_boundary(1);
      if (rnd) rand_inputs();
      t++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    check_reset("por");
    sys_rst_n = 1'b1;
    model_reset();
    t = 0;

    // Static picture at the origin.
    run(400, 1'b0);
    // Steady motion long enough to bounce off every wall.
    move_en = 1'b1;
    step    = 4'd5;
    run(FT * 9, 1'b0);

    // Asynchronous reset in the middle of a visible line while moving.
    for (int i = 0; i < HT && (t % HT) != 11; i++) run(1, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check_reset("arst_now");
    @(negedge sys_clk);
    check_reset("arst_hold");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    t = 0;
    step = 4'd3;
    run(FT * 4, 1'b0);

    // Frozen by zero step, then step raised mid-frame.
    step = 4'd0;
    run(FT * 2 + 100, 1'b0);
    step = 4'd9;
    run(FT * 3, 1'b0);
    // Mid-frame drop of move_en.
    run(150, 1'b0);
    move_en = 1'b0;
    run(FT * 2, 1'b0);
    move_en = 1'b1;

    // Randomised move_en/step changes at arbitrary points in the frame.
    run(5000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
